// File: rtl/timed_main_memory.sv
// ---------------------------------------------------------------------------
// timed_main_memory
//
// Clocked main-memory model that sits below the last-level cache. One access
// is in flight at a time. Each access completes a fixed LATENCY cycles after
// it is accepted. Writes are masked at WORD_BITS granularity. Addresses at or
// above DEPTH are flagged with resp_err and never touch the array.
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   req_valid    request present          req_ready   block can accept
//   req_write    1 = write, 0 = read      req_addr    block address
//   req_wdata    write data (one block)   req_wmask   per-word write enable
//   resp_valid   response present         resp_ready  consumer takes response
//   resp_rdata   read data (0 for writes and errors)
//   resp_write   echoes req_write of the completed access
//   resp_err     access was at an address >= DEPTH
//
// Timing
//   The accept edge loads the counter with LATENCY-1. The edge on which the
//   counter reads 1 (or the accept edge itself when LATENCY==1) enters RESP,
//   performs the array access and loads the response registers. resp_valid
//   therefore shows up in the LATENCY-th cycle after the accept cycle, and
//   the earliest next accept is LATENCY+1 cycles after the previous one.
//
// The storage array has no reset: contents survive rst_n. It is expected to
// power up cleared (simulator / FPGA initial contents).
// ---------------------------------------------------------------------------
module timed_main_memory #(
   parameter int BLOCK_BITS = 512,
   parameter int WORD_BITS  = 32,
   parameter int DEPTH      = 4096,
   parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int LATENCY    = 4,
   parameter int MASK_W     = BLOCK_BITS / WORD_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [BLOCK_BITS-1:0] req_wdata,
   input  logic [MASK_W-1:0]     req_wmask,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [BLOCK_BITS-1:0] resp_rdata,
   output logic                  resp_write,
   output logic                  resp_err
);

   // Counter holds at most LATENCY-1.
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   generate
      if (LATENCY < 1) begin : g_bad_latency
         $error("timed_main_memory: LATENCY must be >= 1");
      end
      if ((BLOCK_BITS % WORD_BITS) != 0) begin : g_bad_word
         $error("timed_main_memory: BLOCK_BITS must be a multiple of WORD_BITS");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic                    wr_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [BLOCK_BITS-1:0]   wdata_q;
   logic [MASK_W-1:0]       wmask_q;

   logic [BLOCK_BITS-1:0]   rdata_q;
   logic                    rwrite_q;
   logic                    rerr_q;

   logic [BLOCK_BITS-1:0]   mem_q [DEPTH];

   // FSM strobes
   logic                    accept;   // request handshake this edge
   logic                    commit;   // array access + response load this edge
   logic                    done;     // response handshake this edge

   // ------------------------------------------------------------------------
   // Operation source. With LATENCY==1 the access commits on the accept edge,
   // before the request has been latched, so it must come straight from the
   // request port. Otherwise it comes from the latched copy.
   // ------------------------------------------------------------------------
   logic                    op_wr;
   logic [ADDR_W-1:0]       op_addr;
   logic [BLOCK_BITS-1:0]   op_wdata;
   logic [MASK_W-1:0]       op_wmask;
   logic                    op_in_range;

   assign op_wr       = (LATENCY == 1) ? req_write : wr_q;
   assign op_addr     = (LATENCY == 1) ? req_addr  : addr_q;
   assign op_wdata    = (LATENCY == 1) ? req_wdata : wdata_q;
   assign op_wmask    = (LATENCY == 1) ? req_wmask : wmask_q;
   // DEPTH need not be a power of two, so ADDR_W can reach past the array.
   assign op_in_range = (int'(op_addr) < DEPTH);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      done    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               cnt_d  = CNT_W'(LATENCY - 1);
               if (LATENCY > 1) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_RESP;
                  commit  = 1'b1;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            // <= rather than == keeps a corrupted counter from hanging here.
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_RESP;
               commit  = 1'b1;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
               done    = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Control and response registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wmask_q  <= '0;
         rdata_q  <= '0;
         rwrite_q <= 1'b0;
         rerr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;

         if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
         end

         if (commit) begin
            rwrite_q <= op_wr;
            rerr_q   <= !op_in_range;
            rdata_q  <= (!op_wr && op_in_range) ? mem_q[op_addr] : '0;
         end else if (done) begin
            rwrite_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Storage array: no reset, word-masked write on the commit edge. The
   // rst_n term keeps a request presented during reset from writing when
   // LATENCY==1 (commit is then decoded from the request port).
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst_n && commit && op_wr && op_in_range) begin
         for (int w = 0; w < MASK_W; w++) begin
            if (op_wmask[w]) begin
               mem_q[op_addr][w*WORD_BITS +: WORD_BITS] <= op_wdata[w*WORD_BITS +: WORD_BITS];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: pure decode of registered state, no path from req_valid.
   // ------------------------------------------------------------------------
   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_write = rwrite_q;
   assign resp_err   = rerr_q;

`ifndef SYNTHESIS
   // A stalled response must not change under the consumer.
   a_resp_stable : assert property (
      @(posedge clk) disable iff (!rst_n)
      (resp_valid && !resp_ready) |=>
         (resp_valid && $stable(resp_rdata) && $stable(resp_write) && $stable(resp_err))
   );
`endif

endmodule
